// File: rtl/hazard_scoreboard.sv
// Per-register RAW hazard scoreboard: valid bit + latency countdown per entry, combinational stall, registered pending count.
// Optional stall-cycle performance counter enabled by macro SB_PERF_CNT_EN.
module hazard_scoreboard #(
  parameter int LAT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       p0_addr_ID,
  input  logic [3:0]       p1_addr_ID,
  input  logic             p0_re,
  input  logic             p1_re,
  input  logic             issue_valid,
  input  logic             issue_we,
  input  logic [3:0]       issue_dst,
  input  logic [LAT_W-1:0] issue_lat,
  input  logic             wb_we,
  input  logic [3:0]       wb_addr,
  input  logic             flush,
  output logic             stall_p0,
  output logic             stall_p1,
  output logic             stall,
  output logic [4:0]       pending_cnt
`ifdef SB_PERF_CNT_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  logic [15:0]      valid_q;
  logic [15:0]      valid_d;
  logic [LAT_W-1:0] cnt_q [16];
  logic [LAT_W-1:0] cnt_d [16];
  logic             issue_ok;
  logic [4:0]       pop_d;

  always_comb begin
    stall_p0 = p0_re & valid_q[p0_addr_ID] & (cnt_q[p0_addr_ID] != '0);
    stall_p1 = p1_re & valid_q[p1_addr_ID] & (cnt_q[p1_addr_ID] != '0);
    stall    = stall_p0 | stall_p1;
    issue_ok = issue_valid & issue_we & ~stall;
  end

  // Priority, lowest to highest: countdown, writeback, issue, flush.
  always_comb begin
    valid_d = valid_q;
    pop_d   = '0;
    for (int i = 0; i < 16; i++) begin
      cnt_d[i] = cnt_q[i];
      if (valid_q[i] && (cnt_q[i] != '0))
        cnt_d[i] = cnt_q[i] - LAT_W'(1);
      if (wb_we && (wb_addr == 4'(i))) begin
        valid_d[i] = 1'b0;
        cnt_d[i]   = '0;
      end
      if (issue_ok && (issue_dst == 4'(i))) begin
        valid_d[i] = 1'b1;
        cnt_d[i]   = issue_lat;
      end
      if (flush) begin
        valid_d[i] = 1'b0;
        cnt_d[i]   = '0;
      end
      pop_d = pop_d + 5'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q     <= '0;
      pending_cnt <= '0;
      for (int i = 0; i < 16; i++)
        cnt_q[i] <= '0;
    end else begin
      valid_q     <= valid_d;
      pending_cnt <= pop_d;
      for (int i = 0; i < 16; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef SB_PERF_CNT_EN
  // Survives flush on purpose; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != 16'hFFFF))
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against an array-based reference model.
module tb_hazard_scoreboard;
  localparam int LAT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       p0_addr_ID, p1_addr_ID;
  logic             p0_re, p1_re;
  logic             issue_valid, issue_we;
  logic [3:0]       issue_dst;
  logic [LAT_W-1:0] issue_lat;
  logic             wb_we;
  logic [3:0]       wb_addr;
  logic             flush;
  logic             stall_p0, stall_p1, stall;
  logic [4:0]       pending_cnt;
`ifdef SB_PERF_CNT_EN
  logic [15:0]      stall_cycles;
`endif

  hazard_scoreboard #(.LAT_W(LAT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_addr_ID(p0_addr_ID), .p1_addr_ID(p1_addr_ID),
    .p0_re(p0_re), .p1_re(p1_re),
    .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_dst(issue_dst), .issue_lat(issue_lat),
    .wb_we(wb_we), .wb_addr(wb_addr), .flush(flush),
    .stall_p0(stall_p0), .stall_p1(stall_p1), .stall(stall),
    .pending_cnt(pending_cnt)
`ifdef SB_PERF_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: which registers are in flight and cycles left before bypass.
  bit m_valid [16];
  int m_cd    [16];
  int m_perf;
  bit known = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_hz(input bit re, input logic [3:0] a);
    return re && m_valid[a] && (m_cd[a] > 0);
  endfunction

  function automatic int m_pending();
    int n = 0;
    for (int i = 0; i < 16; i++) n += m_valid[i];
    return n;
  endfunction

  task automatic idle();
    rst_n = 1; p0_re = 0; p1_re = 0; p0_addr_ID = 0; p1_addr_ID = 0;
    issue_valid = 0; issue_we = 0; issue_dst = 0; issue_lat = 0;
    wb_we = 0; wb_addr = 0; flush = 0;
  endtask

  task automatic do_issue(input int dst, input int lat);
    issue_valid = 1; issue_we = 1; issue_dst = 4'(dst); issue_lat = LAT_W'(lat);
  endtask

  // Check outputs against the model, take one edge, advance the model.
  task automatic step();
    bit s0, s1;
    #1;
    s0 = m_hz(p0_re, p0_addr_ID);
    s1 = m_hz(p1_re, p1_addr_ID);
    if (known) begin
      chk("stall_p0", stall_p0, s0);
      chk("stall_p1", stall_p1, s1);
      chk("stall", stall, s0 | s1);
      chk("pending_cnt", pending_cnt, m_pending());
`ifdef SB_PERF_CNT_EN
      chk("stall_cycles", stall_cycles, m_perf);
`endif
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_cd[i] = 0; end
      m_perf = 0;
      known  = 1;
    end else begin
      if ((s0 | s1) && m_perf < 65535) m_perf++;
      if (flush) begin
        for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_cd[i] = 0; end
      end else begin
        for (int i = 0; i < 16; i++)
          if (m_valid[i] && m_cd[i] > 0) m_cd[i]--;
        if (wb_we) begin m_valid[wb_addr] = 0; m_cd[wb_addr] = 0; end
        if (issue_valid && issue_we && !(s0 | s1)) begin
          m_valid[issue_dst] = 1; m_cd[issue_dst] = int'(issue_lat);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic read0(input int a);
    p0_re = 1; p0_addr_ID = 4'(a);
  endtask

  initial begin
    @(negedge clk);
    idle(); rst_n = 0;
    step(); step();
    // Stalls must be clear right after reset.
    idle(); read0(0); p1_re = 1; p1_addr_ID = 4'd15;
    #1; chk("post_reset_stall", stall, 0); chk("post_reset_cnt", pending_cnt, 0);
    step();

    // Load-use: one stall cycle.
    idle(); do_issue(3, 1); step();
    idle(); read0(3); #1; chk("lu_stall", stall, 1); chk("lu_cnt", pending_cnt, 1); step();
    idle(); read0(3); #1; chk("lu_clear", stall, 0); step();
    idle(); wb_we = 1; wb_addr = 3; step();

    // ALU result: never stalls, retires on writeback.
    idle(); do_issue(5, 0); step();
    idle(); read0(5); #1; chk("alu_stall", stall, 0); chk("alu_cnt", pending_cnt, 1); step();
    idle(); wb_we = 1; wb_addr = 5; step();
    idle(); #1; chk("alu_wb_cnt", pending_cnt, 0); step();

    // WAW with a stalled second issue, then accepted without the read.
    idle(); do_issue(7, 3); step();
    idle(); do_issue(7, 1); read0(7); #1; chk("waw_stall", stall, 1); step();
    idle(); do_issue(7, 1); step();
    idle(); read0(7); #1; chk("waw_cd1", stall, 1); step();
    idle(); read0(7); step();

    // Issue and writeback to the same register: issue wins.
    idle(); do_issue(2, 2); wb_we = 1; wb_addr = 2; step();
    idle(); read0(2); #1; chk("iwb_stall1", stall, 1); step();
    idle(); read0(2); #1; chk("iwb_stall2", stall, 1); step();
    idle(); read0(2); #1; chk("iwb_stall3", stall, 0); step();

    // Flush with multi-cycle results in flight.
    idle(); do_issue(1, 3); step();
    idle(); do_issue(4, 3); step();
    idle(); do_issue(9, 3); step();
    idle(); flush = 1; do_issue(10, 3); wb_we = 1; wb_addr = 1; step();
    idle(); read0(9); p1_re = 1; p1_addr_ID = 4;
    #1; chk("flush_cnt", pending_cnt, 0); chk("flush_stall", stall, 0); step();

    // Reset mid-countdown, overriding an issue.
    idle(); do_issue(6, 3); step();
    idle(); rst_n = 0; do_issue(8, 3); step();
    idle(); read0(6); #1; chk("rst_cnt", pending_cnt, 0); chk("rst_stall", stall, 0); step();

    // Randomized traffic on a narrowed register range to provoke hazards.
    for (int n = 0; n < 4000; n++) begin
      idle();
      rst_n       = ($urandom % 80) != 0;
      flush       = ($urandom % 30) == 0;
      issue_valid = $urandom % 2;
      issue_we    = ($urandom % 4) != 0;
      issue_dst   = 4'($urandom % 8);
      issue_lat   = LAT_W'($urandom);
      p0_re       = $urandom % 2;
      p1_re       = $urandom % 2;
      p0_addr_ID  = 4'($urandom % 8);
      p1_addr_ID  = 4'((n % 7 == 0) ? $urandom : $urandom % 8);
      wb_we       = ($urandom % 3) == 0;
      wb_addr     = 4'($urandom % 8);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
